// File: rtl/mem_vec_sequencer_if.sv
// mem_vec_sequencer_if
// Data-memory port between the vector memory sequencer (master) and the
// data memory (slave).
//   mem_addr  : byte address of the current beat
//   mem_wdata : store word of the current beat
//   mem_we    : write strobe
//   mem_re    : read strobe
//   mem_rdata : read word, valid the cycle after mem_re
interface mem_vec_sequencer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_vec_sequencer.sv
// mem_vec_sequencer
// Serialises a memory-stage vector (16 lanes) or scalar (lane 0) load/store
// onto a single 32-bit data-memory port, one word per cycle, stalling the
// pipeline until the access completes.
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   ALUResultM      : per-lane ALU result; lane 0 is the byte base address
//   WriteDataM      : per-lane store data
//   MemWriteM       : store request (wins when MemtoRegM is also set)
//   MemtoRegM       : load request
//   v_s_m           : 1 = 16-lane vector access, 0 = scalar access
//   mem             : data-memory port (master side)
//   StallM          : holds EX/MEM and earlier stages
//   ReadDataM       : gathered load result, held until the next load
//   done            : one-cycle completion pulse
// Build option:
//   SCALAR_FASTPATH_EN : scalar stores are issued combinationally from IDLE
//                        in a single cycle without stalling.
//
// state  | meaning
// IDLE   | waiting for a request
// RUN    | issuing one memory beat per cycle
// WAIT   | load only: capturing the last read word
// DONE   | completion pulse, request ignored
module mem_vec_sequencer (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0][31:0] ALUResultM,
  input  logic [15:0][31:0] WriteDataM,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic              v_s_m,
  mem_vec_sequencer_if.master mem,
  output logic              StallM,
  output logic [15:0][31:0] ReadDataM,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              vec_q;
  logic              store_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              re_q;
  logic              done_q;
  logic              rd_pend_q;
  logic [3:0]        rd_idx_q;
  logic [15:0][31:0] read_q;

  logic              req;
  logic              fast;
  logic              last;
  logic [3:0]        cnt_inc;

  assign req     = MemWriteM | MemtoRegM;
  assign cnt_inc = cnt_q + 4'd1;
  // Scalar accesses only ever have beat 0.
  assign last    = vec_q ? (cnt_q == 4'd15) : 1'b1;

`ifdef SCALAR_FASTPATH_EN
  assign fast = (state_q == S_IDLE) && MemWriteM && !v_s_m;
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      vec_q     <= 1'b0;
      store_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 4'd0;
      read_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;

      // Read word of the previous beat arrives this cycle.
      if (rd_pend_q) begin
        read_q[rd_idx_q] <= mem.mem_rdata;
        if (!vec_q) begin
          for (int l = 1; l < 16; l++) read_q[l] <= 32'd0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (req && !fast) begin
            state_q <= S_RUN;
            cnt_q   <= 4'd0;
            vec_q   <= v_s_m;
            store_q <= MemWriteM;
            addr_q  <= ALUResultM[0];
            wdata_q <= MemWriteM ? WriteDataM[0] : 32'd0;
            we_q    <= MemWriteM;
            re_q    <= !MemWriteM;
          end
        end
        S_RUN: begin
          cnt_q     <= cnt_inc;
          rd_pend_q <= !store_q;
          rd_idx_q  <= cnt_q;
          if (last) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            state_q <= store_q ? S_DONE : S_WAIT;
            done_q  <= store_q;
          end else begin
            addr_q  <= addr_q + 32'd4;
            wdata_q <= store_q ? WriteDataM[cnt_inc] : 32'd0;
          end
        end
        S_WAIT: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_we    = we_q | fast;
  assign mem.mem_re    = re_q;
  assign mem.mem_addr  = fast ? ALUResultM[0] : addr_q;
  assign mem.mem_wdata = fast ? WriteDataM[0] : wdata_q;

  assign StallM    = ((state_q == S_IDLE) && req && !fast) ||
                     (state_q == S_RUN) || (state_q == S_WAIT);
  assign done      = done_q | fast;
  assign ReadDataM = read_q;

endmodule

// File: doc/mem_vec_sequencer.md
MEM_VEC_SEQUENCER -- requirements
Module: mem_vec_sequencer

Interface
REQ-001 SHALL have clock CLK: input, 1 bit, rising-edge clock.
REQ-002 SHALL have reset RST: input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have ALUResultM: input, [15:0][31:0], memory-stage ALU result per lane; lane 0 is the byte base address.
REQ-004 SHALL have WriteDataM: input, [15:0][31:0], store data per lane.
REQ-005 SHALL have MemWriteM: input, 1 bit, store request.
REQ-006 SHALL have MemtoRegM: input, 1 bit, load request.
REQ-007 SHALL have v_s_m: input, 1 bit, 1 = vector (16 lanes), 0 = scalar (lane 0 only).
REQ-008 SHALL have mem_addr: output, 32 bits, data-memory byte address.
REQ-009 SHALL have mem_wdata: output, 32 bits, data-memory write word.
REQ-010 SHALL have mem_we: output, 1 bit, data-memory write strobe.
REQ-011 SHALL have mem_re: output, 1 bit, data-memory read strobe.
REQ-012 SHALL have mem_rdata: input, 32 bits, read word, valid exactly one cycle after mem_re.
REQ-013 SHALL have StallM: output, 1 bit, holds the EX/MEM register and earlier stages.
REQ-014 SHALL have ReadDataM: output, [15:0][31:0], gathered load result.
REQ-015 SHALL have done: output, 1 bit, one-cycle pulse on access completion.

Function
REQ-016 SHALL define req = MemWriteM | MemtoRegM; if both are set, the access SHALL be a store and no read SHALL be issued.
REQ-017 SHALL define beat count N = 16 when v_s_m = 1 and N = 1 when v_s_m = 0.
REQ-018 SHALL implement FSM states IDLE, RUN, WAIT, DONE.
REQ-019 IDLE SHALL go to RUN with beat counter = 0 when req = 1, and SHALL otherwise stay in IDLE.
REQ-020 In RUN, beat i SHALL drive mem_addr = ALUResultM[0] + 4*i (modulo 2^32, wrap permitted) and SHALL assert exactly one of mem_we or mem_re.
REQ-021 For a store beat, mem_wdata SHALL equal WriteDataM[i].
REQ-022 RUN SHALL increment the counter each cycle; at i = N-1 it SHALL go to WAIT for a load or to DONE for a store.
REQ-023 For a load, mem_rdata SHALL be captured into ReadDataM[i] the cycle after beat i; WAIT SHALL capture the final word and then go to DONE.
REQ-024 A scalar load SHALL write lane 0 and clear lanes 1-15 to 0.
REQ-025 DONE SHALL assert done = 1 for one cycle, ignore req, and go to IDLE.
REQ-026 StallM SHALL be combinational: (IDLE & req) | RUN | WAIT; it SHALL be 0 in DONE.
REQ-027 Latency: a vector store SHALL stall 17 cycles, a vector load 18, and a scalar load 3.
REQ-028 ReadDataM SHALL hold its last value until the next load captures.
REQ-029 mem_we and mem_re SHALL be 0 outside RUN, except as stated in REQ-034.
REQ-030 The design SHALL require inputs to be stable while StallM = 1; changes during stall SHALL be ignored for control, with the beat count latched at IDLE->RUN.

Reset
REQ-031 RST SHALL force state IDLE, counter 0, ReadDataM 0, done 0, mem_we 0, mem_re 0, mem_addr 0, and mem_wdata 0.
REQ-032 RST asserted mid-access SHALL abort the access immediately, with no further memory strobes; the in-flight read data SHALL be discarded.

Configuration
REQ-033 Macro SCALAR_FASTPATH_EN SHALL control scalar-store handling.
REQ-034 With SCALAR_FASTPATH_EN defined, a scalar store in IDLE SHALL drive mem_we = 1, mem_addr = ALUResultM[0], and mem_wdata = WriteDataM[0] combinationally, with StallM = 0, done = 1 in the same cycle, and no state change.
REQ-035 Without SCALAR_FASTPATH_EN, a scalar store SHALL use IDLE->RUN->DONE, stalling 2 cycles.

Verification
REQ-036 Vector store, base 0x100, WriteDataM[i] = i+1 -> 16 consecutive mem_we beats at addresses 0x100..0x13C with data 1..16, StallM high 17 cycles, then a done pulse.
REQ-037 Vector load, base 0x200, memory word at 0x200+4i = 0xA0+i -> ReadDataM[i] = 0xA0+i for all i, done on cycle 19.
REQ-038 Vector store, base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x34.
REQ-039 MemWriteM = 1 and MemtoRegM = 1 together -> store only, mem_re never asserted.
REQ-040 RST pulsed at vector-load beat 5 -> next cycle IDLE, ReadDataM = 0, no strobes, StallM = req.
REQ-041 Scalar store to 0x40 of data 0x55 -> with SCALAR_FASTPATH_EN: same-cycle mem_we, StallM = 0; without it: StallM = 1 for 2 cycles, then done.
